// File: rtl/addmul_pkg.sv
// Shared definitions for the addmul scheduler: FSM encoding, datapath widths
// and the 9-bit add/subtract helper used by pipeline stage 2.
package addmul_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int OPW    = 8;
    localparam int SUMW   = 9;
    localparam int RESW   = 16;
    localparam int NSTAGE = 3;

    // Subtraction wraps modulo 2^SUMW, which the 9-bit result width gives for free.
    function automatic logic [SUMW-1:0] addsub(input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b,
                                               input logic           add);
        return add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    endfunction

endpackage

// File: rtl/addmul_sched_if.sv
// Request/response bus between client blocks and the addmul scheduler:
// packed per-requester operands in, one tagged result stream out.
interface addmul_sched_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N*8-1:0] req_c;
    logic [N-1:0]   req_s;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [15:0]    rsp_d;

    modport master (
        output req_valid, req_a, req_b, req_c, req_s,
        input  req_ready, rsp_valid, rsp_id, rsp_d
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_s,
        output req_ready, rsp_valid, rsp_id, rsp_d
    );
endinterface

// File: rtl/addmul_pipe.sv
// Three-stage (a +/- b) * c datapath. Sideband (valid/id/zero) advances every
// cycle; operand and result registers only load when their stage enable is set.
module addmul_pipe
    import addmul_pkg::*;
#(
    parameter int IDW = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [OPW-1:0]    in_a_i,
    input  logic [OPW-1:0]    in_b_i,
    input  logic [OPW-1:0]    in_c_i,
    input  logic              in_s_i,
    input  logic [IDW-1:0]    in_id_i,
    input  logic [NSTAGE-1:0] stage_en_i,
    output logic              s1_valid_o,
    output logic              s1_zero_o,
    output logic              s2_valid_o,
    output logic              s2_zero_o,
    output logic              busy_o,
    output logic              rsp_valid_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [RESW-1:0]   rsp_d_o
);

    logic                 s1_valid_q, s2_valid_q, s3_valid_q;
    logic                 s1_zero_q,  s2_zero_q,  s3_zero_q;
    logic [IDW-1:0]       s1_id_q,    s2_id_q,    s3_id_q;
    logic [OPW-1:0]       s1_a_q, s1_b_q, s1_c_q, s2_c_q;
    logic                 s1_s_q;
    logic [SUMW-1:0]      s2_sum_q, s2_sum_d;
    logic [RESW-1:0]      s3_prod_q, s3_prod_d;
    logic [SUMW+OPW-1:0]  prod_full;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s3_zero_q  <= 1'b0;
            s1_id_q    <= '0;
            s2_id_q    <= '0;
            s3_id_q    <= '0;
        end else begin
            s1_valid_q <= in_valid_i;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s1_zero_q  <= (in_c_i == '0);
            s2_zero_q  <= s1_zero_q;
            s3_zero_q  <= s2_zero_q;
            s1_id_q    <= in_id_i;
            s2_id_q    <= s1_id_q;
            s3_id_q    <= s2_id_q;
        end
    end

    always_comb begin
        s2_sum_d  = addsub(s1_a_q, s1_b_q, s1_s_q);
        prod_full = {{OPW{1'b0}}, s2_sum_q} * {{SUMW{1'b0}}, s2_c_q};
        s3_prod_d = prod_full[RESW-1:0];
    end

    // NOTE: data registers carry no reset; the cleared valid bits already mark them as don't-care.
    always_ff @(posedge CLK) begin
        if (stage_en_i[0]) begin
            s1_a_q <= in_a_i;
            s1_b_q <= in_b_i;
            s1_c_q <= in_c_i;
            s1_s_q <= in_s_i;
        end
        if (stage_en_i[1]) begin
            s2_sum_q <= s2_sum_d;
            s2_c_q   <= s1_c_q;
        end
        if (stage_en_i[2]) begin
            s3_prod_q <= s3_prod_d;
        end
    end

    // Zero-flagged ops never loaded stage 3, so the mux must supply their zero result.
    assign rsp_valid_o = s3_valid_q;
    assign rsp_id_o    = s3_valid_q ? s3_id_q : '0;
    assign rsp_d_o     = (s3_valid_q && !s3_zero_q) ? s3_prod_q : '0;

    assign s1_valid_o  = s1_valid_q;
    assign s1_zero_o   = s1_zero_q;
    assign s2_valid_o  = s2_valid_q;
    assign s2_zero_o   = s2_zero_q;
    assign busy_o      = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: rtl/addmul_sched.sv
// Round-robin front end for the shared addmul pipeline: power FSM, arbiter
// and per-stage clock-gate enables.
module addmul_sched
    import addmul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              en,
    addmul_sched_if.slave     bus,
    output logic [NSTAGE-1:0] stage_en,
    output logic              busy,
    output logic [1:0]        state
);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           grant_allow;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] arb_idx;
    logic [N-1:0]   grant;
    logic [OPW-1:0] op_a, op_b, op_c;
    logic           op_s;
    logic           s1_valid, s1_zero, s2_valid, s2_zero;

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q <= ST_OFF;
            ptr_q   <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:   if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (en)         state_d = ST_RUN;
                else if (!busy) state_d = ST_OFF;
            end
            default:  state_d = ST_OFF;
        endcase
    end

    always_comb begin
        grant_allow = 1'b0;
        case (state_q)
            ST_RUN:  grant_allow = 1'b1;
            default: grant_allow = 1'b0;
        endcase
    end

    assign state = state_q;

    // Cyclic search starting one past the last winner.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_id  = '0;
        arb_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            arb_idx = IDW'((int'(ptr_q) + k) % N);
            if (grant_allow && !grant_vld && bus.req_valid[arb_idx]) begin
                grant_vld = 1'b1;
                grant_id  = arb_idx;
            end
        end
        ptr_d = grant_vld ? grant_id : ptr_q;
    end

    always_comb begin
        grant = '0;
        op_a  = '0;
        op_b  = '0;
        op_c  = '0;
        op_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant[i] = grant_vld && (grant_id == IDW'(i));
            if (grant[i]) begin
                op_a = bus.req_a[i*OPW +: OPW];
                op_b = bus.req_b[i*OPW +: OPW];
                op_c = bus.req_c[i*OPW +: OPW];
                op_s = bus.req_s[i];
            end
        end
    end

    assign bus.req_ready = grant;
    assign stage_en      = {s2_valid & ~s2_zero, s1_valid & ~s1_zero, grant_vld};

    addmul_pipe #(.IDW(IDW)) u_pipe (
        .CLK         (CLK),
        .reset       (reset),
        .in_valid_i  (grant_vld),
        .in_a_i      (op_a),
        .in_b_i      (op_b),
        .in_c_i      (op_c),
        .in_s_i      (op_s),
        .in_id_i     (grant_id),
        .stage_en_i  (stage_en),
        .s1_valid_o  (s1_valid),
        .s1_zero_o   (s1_zero),
        .s2_valid_o  (s2_valid),
        .s2_zero_o   (s2_zero),
        .busy_o      (busy),
        .rsp_valid_o (bus.rsp_valid),
        .rsp_id_o    (bus.rsp_id),
        .rsp_d_o     (bus.rsp_d)
    );

endmodule

// File: tb/tb_addmul_sched.sv
// Directed and randomized bench for addmul_sched; a cycle-level reference
// model (delay line of expected ops, round-robin rule, power FSM rules) predicts outputs.
module tb_addmul_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct {
        bit v;
        int id;
        bit z;
        int d;
    } op_t;

    logic       CLK   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic [2:0] stage_en;
    logic       busy;
    logic [1:0] state;

    addmul_sched_if #(.N(N), .IDW(IDW)) bus ();

    addmul_sched #(.N(N), .IDW(IDW)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .en       (en),
        .bus      (bus),
        .stage_en (stage_en),
        .busy     (busy),
        .state    (state)
    );

    always #5 CLK = ~CLK;

    int         n_pass  = 0;
    int         n_total = 0;
    op_t        dl[3];
    int         ptr_m;
    int         st_m;
    logic [7:0] ra[N];
    logic [7:0] rb[N];
    logic [7:0] rc[N];
    logic [N-1:0] rv;
    logic [N-1:0] rs;
    bit         got_v;
    int         got_id;
    int         got_d;
    logic [2:0] last_se;
    logic [N-1:0] last_ready;
    int         rsp_cnt;
    int         id_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_result(input int a, input int b, input int c, input bit s);
        int sum;
        sum = s ? (a + b) : (a - b);
        sum = ((sum % 512) + 512) % 512;
        return (sum * c) % 65536;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            dl[i].v = 0; dl[i].id = 0; dl[i].z = 0; dl[i].d = 0;
        end
        ptr_m = N - 1;
        st_m  = 0;
    endtask

    task automatic drive_bus();
        bus.req_valid = rv;
        bus.req_s     = rs;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*8 +: 8] = ra[i];
            bus.req_b[i*8 +: 8] = rb[i];
            bus.req_c[i*8 +: 8] = rc[i];
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input bit en_v);
        int   g;
        op_t  nw;
        bit   busy_m;
        logic [31:0] exp_ready;
        en = en_v;
        drive_bus();
        #1;
        g = -1;
        if (st_m == 1) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (ptr_m + k) % N;
                if (g < 0 && rv[i]) g = i;
            end
        end
        exp_ready = (g < 0) ? 32'd0 : (32'd1 << g);
        busy_m    = dl[0].v || dl[1].v || dl[2].v;
        check("req_ready", {28'd0, bus.req_ready}, exp_ready);
        check("stage_en", {29'd0, stage_en},
              {29'd0, dl[1].v && !dl[1].z, dl[0].v && !dl[0].z, g >= 0});
        check("busy", {31'd0, busy}, {31'd0, busy_m});
        check("state", {30'd0, state}, st_m);
        last_se    = stage_en;
        last_ready = bus.req_ready;
        nw.v = 0; nw.id = 0; nw.z = 0; nw.d = 0;
        if (g >= 0) begin
            nw.v  = 1;
            nw.id = g;
            nw.z  = (rc[g] == 8'd0);
            nw.d  = ref_result(int'(ra[g]), int'(rb[g]), int'(rc[g]), rs[g]);
        end
        @(posedge CLK);
        dl[2] = dl[1];
        dl[1] = dl[0];
        dl[0] = nw;
        if (g >= 0) ptr_m = g;
        case (st_m)
            0: if (en_v) st_m = 1;
            1: if (!en_v) st_m = 2;
            2: if (en_v) st_m = 1; else if (!busy_m) st_m = 0;
            default: st_m = 0;
        endcase
        #1;
        check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, dl[2].v});
        if (dl[2].v) begin
            check("rsp_id", {30'd0, bus.rsp_id}, dl[2].id);
            check("rsp_d", {16'd0, bus.rsp_d}, dl[2].d);
        end
        got_v  = bus.rsp_valid;
        got_id = int'(bus.rsp_id);
        got_d  = int'(bus.rsp_d);
        if (got_v) begin
            rsp_cnt++;
            id_q.push_back(got_id);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        en    = 1'b0;
        rv    = '0;
        drive_bus();
        @(posedge CLK);
        #1;
        model_reset();
        check("rst_state", {30'd0, state}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_stage_en", {29'd0, stage_en}, 0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check("rst_rsp_id", {30'd0, bus.rsp_id}, 0);
        check("rst_rsp_d", {16'd0, bus.rsp_d}, 0);
        check("rst_req_ready", {28'd0, bus.req_ready}, 0);
        reset   = 1'b1;
        rsp_cnt = 0;
    endtask

    task automatic idle(input int n, input bit en_v);
        rv = '0;
        repeat (n) cycle(en_v);
    endtask

    initial begin
        rv = '0;
        rs = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0; rb[i] = '0; rc[i] = '0;
        end
        model_reset();
        apply_reset();

        // req0 add: (0x10+0x05)*3 = 0x3F; first cycle is still OFF.
        rv = 4'b0001; ra[0] = 8'h10; rb[0] = 8'h05; rc[0] = 8'h03; rs[0] = 1'b1;
        cycle(1);
        cycle(1);
        check("tp0_ready", {28'd0, last_ready}, 32'h1);
        idle(2, 1);
        check("tp0_v", {31'd0, got_v}, 1);
        check("tp0_id", got_id, 0);
        check("tp0_d", got_d, 32'h003F);

        // req1 subtract: (0x05-0x10) mod 512 = 0x1F5, *2 = 0x3EA.
        rv = 4'b0010; ra[1] = 8'h05; rb[1] = 8'h10; rc[1] = 8'h02; rs[1] = 1'b0;
        cycle(1);
        idle(2, 1);
        check("tp1_id", got_id, 1);
        check("tp1_d", got_d, 32'h03EA);

        // req2 maximum operands: 0x1FE*0xFF truncated = 0xFC02.
        rv = 4'b0100; ra[2] = 8'hFF; rb[2] = 8'hFF; rc[2] = 8'hFF; rs[2] = 1'b1;
        cycle(1);
        idle(2, 1);
        check("tp2_id", got_id, 2);
        check("tp2_d", got_d, 32'hFC02);

        // req3 with c=0: only stage 1 is enabled, result forced to zero.
        rv = 4'b1000; ra[3] = 8'h7A; rb[3] = 8'h11; rc[3] = 8'h00; rs[3] = 1'b1;
        cycle(1);
        check("zero_se0", {29'd0, last_se}, 32'h1);
        rv = '0;
        cycle(1);
        check("zero_se1", {29'd0, last_se}, 0);
        cycle(1);
        check("zero_se2", {29'd0, last_se}, 0);
        check("zero_v", {31'd0, got_v}, 1);
        check("zero_id", got_id, 3);
        check("zero_d", got_d, 0);

        // All requesters valid for 8 cycles: strict rotation 0,1,2,3,0,1,2,3.
        id_q.delete();
        rv = 4'b1111;
        repeat (8) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'($urandom); rb[i] = 8'($urandom);
                rc[i] = 8'($urandom); rs[i] = 1'($urandom);
            end
            cycle(1);
        end
        idle(3, 1);
        check("rr_count", id_q.size(), 8);
        for (int i = 0; i < 8 && i < id_q.size(); i++) check("rr_order", id_q[i], i % 4);

        // Drain: en falls with the third transfer; exactly three results, then OFF.
        rsp_cnt = 0;
        rv = 4'b1111;
        cycle(1);
        cycle(1);
        cycle(0);
        repeat (5) cycle(0);
        check("drain_off", {30'd0, state}, 0);
        check("drain_rsp_cnt", rsp_cnt, 3);
        check("drain_off_se", {29'd0, last_se}, 0);

        // Reset with two ops in flight: they vanish and priority returns to requester 0.
        rv = '0;
        cycle(1);
        rv = 4'b1111;
        cycle(1);
        cycle(1);
        apply_reset();
        idle(3, 0);
        check("rst_no_rsp", rsp_cnt, 0);
        rv = 4'b1111;
        cycle(1);
        cycle(1);
        check("rst_first_grant", {28'd0, last_ready}, 32'h1);
        idle(3, 1);

        // Randomized traffic with occasional en drops and zero multipliers.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'($urandom);
                rb[i] = 8'($urandom);
                rc[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                rs[i] = 1'($urandom);
            end
            rv = N'($urandom);
            cycle($urandom_range(0, 7) != 0);
        end
        idle(4, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
